reg_bank_ctrl: RTL and testbench
================================

REG_BANK_CTRL -- requirements
Module: reg_bank_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning word-address width; the bank holds 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, meaning bits per word, i.e. storage cells per word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, host request present.
REQ-006 SHALL have port req_ready, output, 1, controller accepts a request.
REQ-007 SHALL have port req_wr, input, 1, request type: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, ADDR_W, target word.
REQ-009 SHALL have port req_wdata, input, DATA_W, write data.
REQ-010 SHALL have port rsp_valid, output, 1, response available.
REQ-011 SHALL have port rsp_ready, input, 1, host takes the response.
REQ-012 SHALL have port rsp_rdata, output, DATA_W, read data; 0 for writes.
REQ-013 SHALL have port rsp_err, output, 1, write-verify mismatch.
REQ-014 SHALL have port mem_en, output, 2^ADDR_W, one-hot word enable to the cell array.
REQ-015 SHALL have port mem_wr_bar, output, 1, active-low write strobe to the cells.
REQ-016 SHALL have port mem_rd_bar, output, 1, active-low read strobe to the cells.
REQ-017 SHALL have port mem_din, output, DATA_W, write data to the cells.
REQ-018 SHALL have port mem_dout, input, DATA_W, cell outputs; high-Z when the word is not read-enabled.

Function
REQ-019 SHALL implement the FSM states IDLE, WSTB, RSTB, VSTB, RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid&req_ready at a rising edge.
REQ-021 SHALL latch addr, wdata and wr on handshake, then go to WSTB if wr=1, else to RSTB.
REQ-022 SHALL in WSTB, for exactly one cycle, drive mem_en one-hot[addr], mem_wr_bar=0, mem_rd_bar=1, mem_din=wdata; the cell captures at the edge ending WSTB.
REQ-023 SHALL in RSTB, for exactly one cycle, drive mem_en one-hot[addr], mem_rd_bar=0, mem_wr_bar=1, and sample mem_dout into rsp_rdata at the edge ending RSTB.
REQ-024 SHALL go from WSTB to VSTB when verification is compiled in, and to RESP otherwise; RSTB and VSTB SHALL go to RESP.
REQ-025 SHALL hold rsp_valid=1 in RESP with stable rsp_rdata/rsp_err until rsp_valid&rsp_ready at an edge, then return to IDLE.
REQ-026 SHALL set latency, handshake at edge N: strobe cycle N to N+1, rsp_valid high from edge N+1 (read/write), or N+2 with a write-verify cycle.
REQ-027 SHALL drive all strobes from registers, never both low in a cycle; outside strobe states mem_en=0, both bars=1, mem_din=0.
REQ-028 SHALL ignore req_valid outside IDLE; back-to-back requests SHALL leave a minimum of one IDLE cycle between them.
REQ-029 SHALL wrap nothing: every req_addr in 0..2^ADDR_W-1 is valid, with no out-of-range case.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_wr_bar=1, mem_rd_bar=1, mem_din=0, immediately and regardless of clk.
REQ-031 SHALL abort an in-flight strobe or response on mid-operation reset; a write aborted before its capture edge leaves the cell unchanged, and no response is issued.
REQ-032 SHALL raise req_ready at the first rising edge after rst_n deasserts.

Configuration
REQ-033 SHALL, with WR_VERIFY_EN defined, insert VSTB after WSTB: a read strobe that compares mem_dout with wdata and sets rsp_err=1 on mismatch.
REQ-034 SHALL, without WR_VERIFY_EN, omit VSTB logic entirely and tie rsp_err=0.

Verification
REQ-035 SHALL cover: reset, then write addr 5 data 0xA5 -> mem_en=0x20, mem_wr_bar=0 for one cycle, rsp_valid next, rsp_err=0.
REQ-036 SHALL cover: read addr 5 after that write -> mem_rd_bar=0 for one cycle, rsp_rdata=0xA5.
REQ-037 SHALL cover: rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, further requests ignored.
REQ-038 SHALL cover: WR_VERIFY_EN with the cell model stuck bit0=0, write 0x01 -> rsp_err=1 two cycles after handshake.
REQ-039 SHALL cover: rst_n low during WSTB for addr 2 data 0xFF -> strobes released asynchronously, word 2 unchanged, no rsp_valid.
REQ-040 SHALL cover: write all 8 addresses with value=addr, then read back -> each rsp_rdata equals its address, mem_en always one-hot or zero.

Source files
------------

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl
// Sequencer between a single-request host port and a bank of 2^ADDR_W words of
// DATA_W storage cells. Each accepted request produces one registered strobe
// cycle toward the cell array, followed by a held response.
//
// Optional feature macro: WR_VERIFY_EN
//    When defined, every write is followed by one read-back strobe cycle (VSTB)
//    and rsp_err reports whether the cells returned the written value.
//    When undefined, the read-back logic is absent and rsp_err is tied to 0.
//
// Ports
//    clk        : single clock, rising edge
//    rst_n      : asynchronous active-low reset
//    req_valid  : host request present
//    req_ready  : controller can accept a request (IDLE only)
//    req_wr     : 1 = write, 0 = read
//    req_addr   : target word
//    req_wdata  : write data
//    rsp_valid  : response available
//    rsp_ready  : host takes the response
//    rsp_rdata  : read data (0 for writes)
//    rsp_err    : write-verify mismatch
//    mem_en     : one-hot word enable to the cells
//    mem_wr_bar : active-low write strobe
//    mem_rd_bar : active-low read strobe
//    mem_din    : write data to the cells
//    mem_dout   : cell outputs (high-Z when no word is read-enabled)

module reg_bank_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_wr,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic [(1<<ADDR_W)-1:0] mem_en,
   output logic                   mem_wr_bar,
   output logic                   mem_rd_bar,
   output logic [DATA_W-1:0]      mem_din,
   input  logic [DATA_W-1:0]      mem_dout
);

   localparam int WORDS = 1 << ADDR_W;
   localparam logic [WORDS-1:0] EN_LSB = WORDS'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WSTB = 3'd1,
      RSTB = 3'd2,
      VSTB = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   logic              lat_wr;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              handshake;
   logic [ADDR_W-1:0] addr_src;
   logic [DATA_W-1:0] wdata_src;

   logic [WORDS-1:0]  en_nxt;
   logic              wr_bar_nxt;
   logic              rd_bar_nxt;
   logic [DATA_W-1:0] din_nxt;
   logic              ready_nxt;
   logic              valid_nxt;

   // req_ready is registered, so it stays low during the first cycle after
   // reset release even though the state is already IDLE.
   assign handshake = req_valid & req_ready;

   // The strobe for a fresh request is launched on the very edge that accepts
   // it, so its address/data come straight from the request port; later strobe
   // cycles (the verify read) use the latched copy.
   assign addr_src  = (state == IDLE) ? req_addr  : lat_addr;
   assign wdata_src = (state == IDLE) ? req_wdata : lat_wdata;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (handshake) begin
               state_nxt = req_wr ? WSTB : RSTB;
            end
         end
`ifdef WR_VERIFY_EN
         WSTB: state_nxt = VSTB;
         VSTB: state_nxt = RESP;
`else
         WSTB: state_nxt = RESP;
`endif
         RSTB: state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode of the upcoming state; the results are registered below so
   // every strobe pin comes straight from a flop and lines up with its state.
   always_comb begin
      en_nxt     = '0;
      wr_bar_nxt = 1'b1;
      rd_bar_nxt = 1'b1;
      din_nxt    = '0;
      ready_nxt  = (state_nxt == IDLE);
      valid_nxt  = (state_nxt == RESP);
      case (state_nxt)
         WSTB: begin
            en_nxt     = EN_LSB << addr_src;
            wr_bar_nxt = 1'b0;
            din_nxt    = wdata_src;
         end
         RSTB: begin
            en_nxt     = EN_LSB << addr_src;
            rd_bar_nxt = 1'b0;
         end
`ifdef WR_VERIFY_EN
         VSTB: begin
            en_nxt     = EN_LSB << addr_src;
            rd_bar_nxt = 1'b0;
         end
`endif
         default: begin
            en_nxt     = '0;
         end
      endcase
   end

   // Registered strobes and handshake flags; reset releases the cell strobes
   // immediately so an in-flight write never reaches its capture edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en     <= '0;
         mem_wr_bar <= 1'b1;
         mem_rd_bar <= 1'b1;
         mem_din    <= '0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
      end else begin
         mem_en     <= en_nxt;
         mem_wr_bar <= wr_bar_nxt;
         mem_rd_bar <= rd_bar_nxt;
         mem_din    <= din_nxt;
         req_ready  <= ready_nxt;
         rsp_valid  <= valid_nxt;
      end
   end

   // Request latch and read-data capture. Read data is cleared on acceptance
   // so a write response always reports 0, and sampled at the edge that ends
   // the read strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_rdata <= '0;
      end else begin
         if (state == IDLE && handshake) begin
            lat_wr    <= req_wr;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            rsp_rdata <= '0;
         end else if (state == RSTB) begin
            rsp_rdata <= mem_dout;
         end
      end
   end

`ifdef WR_VERIFY_EN
   // Verify result: compare the read-back word against what was written, at
   // the edge that ends the verify strobe; cleared on each new request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err <= 1'b0;
      end else begin
         if (state == IDLE && handshake) begin
            rsp_err <= 1'b0;
         end else if (state == VSTB && lat_wr) begin
            rsp_err <= (mem_dout != lat_wdata);
         end
      end
   end
`else
   assign rsp_err = 1'b0;

   // Without read-back, the latched request type has no consumer.
   logic unused_lat_wr;
   assign unused_lat_wr = lat_wr;
`endif

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl
// Self-checking bench for reg_bank_ctrl (ADDR_W=3, DATA_W=8). A small cell
// array model answers the strobes; a transaction-timeline reference model
// predicts every DUT output each cycle, and directed sections pin the model
// with literal expectations. Honors WR_VERIFY_EN the same way as the design.

module tb_reg_bank_ctrl;

`ifdef WR_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_wr;
   logic [2:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [7:0] mem_en;
   logic       mem_wr_bar;
   logic       mem_rd_bar;
   logic [7:0] mem_din;
   wire  [7:0] mem_dout;

   int checks = 0;
   int errors = 0;

   // Cell array model: word i starts at 0x3C ^ i; stuck forces bit0 to 0.
   logic [7:0] cells [8] = '{8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h38, 8'h39, 8'h3A, 8'h3B};
   logic       stuck = 1'b0;

   // Reference model state
   logic [7:0] model_mem [8] = '{8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h38, 8'h39, 8'h3A, 8'h3B};
   int         edge_cnt   = 0;
   bit         txn        = 1'b0;
   int         hs_edge    = 0;
   int         resp_start = 0;
   bit         t_wr       = 1'b0;
   logic [2:0] t_addr     = '0;
   logic [7:0] t_wdata    = '0;
   bit         exp_ready  = 1'b0;
   logic [7:0] exp_rdata  = '0;
   bit         exp_err    = 1'b0;

   reg_bank_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_en     (mem_en),
      .mem_wr_bar (mem_wr_bar),
      .mem_rd_bar (mem_rd_bar),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   function automatic int idx_of(input logic [7:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

   // Cells drive their word only while read-enabled
   assign mem_dout = (mem_rd_bar == 1'b0 && mem_en != 8'h00) ? cells[idx_of(mem_en)] : 8'hzz;

   // Cells capture on the rising edge that ends a write strobe
   always @(posedge clk) begin
      if (mem_wr_bar == 1'b0) begin
         for (int i = 0; i < 8; i++) begin
            if (mem_en[i]) cells[i] <= stuck ? (mem_din & 8'hFE) : mem_din;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   // Reference model: tracks one transaction by the edge that accepted it.
   // Strobe occupies the cycle after the accept edge, a write read-back the
   // cycle after that, and the response holds until taken.
   task automatic model_step();
      logic [7:0] mask;
      if (!rst_n) begin
         txn       = 1'b0;
         exp_ready = 1'b0;
         exp_rdata = '0;
         exp_err   = 1'b0;
         return;
      end
      mask = stuck ? 8'hFE : 8'hFF;
      edge_cnt++;
      if (txn) begin
         if (edge_cnt == hs_edge + 1) begin
            if (t_wr) model_mem[t_addr] = t_wdata & mask;
            else      exp_rdata = model_mem[t_addr];
         end
         if (VER == 1 && t_wr && edge_cnt == hs_edge + 2) begin
            exp_err = (model_mem[t_addr] != t_wdata);
         end
         if (edge_cnt - 1 >= resp_start && rsp_ready) txn = 1'b0;
      end else if (exp_ready && req_valid) begin
         txn        = 1'b1;
         hs_edge    = edge_cnt;
         t_wr       = req_wr;
         t_addr     = req_addr;
         t_wdata    = req_wdata;
         resp_start = hs_edge + 1 + ((req_wr && VER == 1) ? 1 : 0);
         exp_rdata  = '0;
         exp_err    = 1'b0;
      end
      exp_ready = !txn;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   // Per-cycle comparison of every DUT output against the model
   initial begin
      bit         wstb;
      bit         rstb;
      logic [7:0] en;
      forever begin
         @(negedge clk);
         wstb = txn && t_wr && edge_cnt == hs_edge;
         rstb = txn && ((!t_wr && edge_cnt == hs_edge) ||
                        (VER == 1 && t_wr && edge_cnt == hs_edge + 1));
         en   = (wstb || rstb) ? (8'h01 << t_addr) : 8'h00;
         checkOutput("req_ready",  32'(req_ready),  32'(exp_ready));
         checkOutput("rsp_valid",  32'(rsp_valid),  32'(txn && edge_cnt >= resp_start));
         checkOutput("rsp_rdata",  32'(rsp_rdata),  32'(exp_rdata));
         checkOutput("rsp_err",    32'(rsp_err),    32'(exp_err));
         checkOutput("mem_en",     32'(mem_en),     32'(en));
         checkOutput("mem_wr_bar", 32'(mem_wr_bar), 32'(!wstb));
         checkOutput("mem_rd_bar", 32'(mem_rd_bar), 32'(!rstb));
         checkOutput("mem_din",    32'(mem_din),    32'(wstb ? t_wdata : 8'h00));
         checkOutput("en_onehot0", 32'($onehot0(mem_en)), 32'(1));
      end
   end

   // Presents one request for one cycle; call just after a negedge with the
   // DUT idle and ready. Returns at the negedge inside the strobe cycle.
   task automatic applyStimulus(input bit wr, input logic [2:0] a, input logic [7:0] d);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // From the strobe-cycle negedge: take the response and return at the
   // negedge of the following idle cycle. Checks read data literally.
   task automatic finishResponse(input bit wr, input logic [7:0] exp_data);
      rsp_ready = 1'b1;
      repeat (1 + ((wr && VER == 1) ? 1 : 0)) @(negedge clk);
      checkOutput("seq_rsp_valid", 32'(rsp_valid), 32'(1));
      if (!wr) checkOutput("seq_rdata", 32'(rsp_rdata), 32'(exp_data));
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit rst_pulse;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_req_ready",  32'(req_ready),  32'(0));
      checkOutput("rst_mem_wr_bar", 32'(mem_wr_bar), 32'(1));
      checkOutput("rst_mem_rd_bar", 32'(mem_rd_bar), 32'(1));
      checkOutput("rst_mem_en",     32'(mem_en),     32'(0));
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_rst", 32'(req_ready), 32'(1));

      // Write 0xA5 to word 5
      applyStimulus(1'b1, 3'd5, 8'hA5);
      checkOutput("w5_mem_en",     32'(mem_en),     32'(8'h20));
      checkOutput("w5_mem_wr_bar", 32'(mem_wr_bar), 32'(0));
      checkOutput("w5_mem_din",    32'(mem_din),    32'(8'hA5));
      checkOutput("w5_req_ready",  32'(req_ready),  32'(0));
      @(negedge clk);
`ifdef WR_VERIFY_EN
      checkOutput("w5_verify_rd_bar", 32'(mem_rd_bar), 32'(0));
      checkOutput("w5_verify_valid",  32'(rsp_valid),  32'(0));
      @(negedge clk);
`endif
      checkOutput("w5_rsp_valid",  32'(rsp_valid),  32'(1));
      checkOutput("w5_rsp_err",    32'(rsp_err),    32'(0));
      checkOutput("w5_wr_bar_off", 32'(mem_wr_bar), 32'(1));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("w5_idle_ready", 32'(req_ready), 32'(1));

      // Read word 5, then stall the response for 4 cycles with a request pending
      applyStimulus(1'b0, 3'd5, 8'h00);
      checkOutput("r5_mem_rd_bar", 32'(mem_rd_bar), 32'(0));
      checkOutput("r5_mem_wr_bar", 32'(mem_wr_bar), 32'(1));
      checkOutput("r5_mem_en",     32'(mem_en),     32'(8'h20));
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 3'd3;
      req_wdata = 8'h77;
      repeat (4) begin
         @(negedge clk);
         checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'(1));
         checkOutput("stall_rsp_rdata", 32'(rsp_rdata), 32'(8'hA5));
         checkOutput("stall_req_ready", 32'(req_ready), 32'(0));
         checkOutput("stall_mem_en",    32'(mem_en),    32'(0));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

`ifdef WR_VERIFY_EN
      // Stuck-at-0 bit0: writing 0x01 must report a verify error
      stuck = 1'b1;
      applyStimulus(1'b1, 3'd1, 8'h01);
      @(negedge clk);
      checkOutput("stuck_valid_early", 32'(rsp_valid), 32'(0));
      @(negedge clk);
      checkOutput("stuck_rsp_valid", 32'(rsp_valid), 32'(1));
      checkOutput("stuck_rsp_err",   32'(rsp_err),   32'(1));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      stuck = 1'b0;
`endif

      // Reset in the middle of the write strobe to word 2
      applyStimulus(1'b1, 3'd2, 8'hFF);
      checkOutput("abort_wr_bar_pre", 32'(mem_wr_bar), 32'(0));
      #1 rst_n = 1'b0;
      #1;
      checkOutput("abort_wr_bar", 32'(mem_wr_bar), 32'(1));
      checkOutput("abort_mem_en", 32'(mem_en),     32'(0));
      checkOutput("abort_din",    32'(mem_din),    32'(0));
      @(posedge clk);
      #1;
      checkOutput("abort_word2", 32'(cells[2]), 32'(8'h3E));
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("abort_no_rsp", 32'(rsp_valid), 32'(0));
      end

      // Write every word with its own address, then read all back
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'(i), 8'(i));
         finishResponse(1'b1, 8'h00);
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'(i), 8'h00);
         finishResponse(1'b0, 8'(i));
      end

      // Randomized traffic with random response back-pressure and rare resets
      rst_pulse = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         #1;
         if (rst_pulse) begin
            rst_n     = 1'b1;
            rst_pulse = 1'b0;
         end else if ($urandom_range(0, 149) == 0) begin
            rst_n     = 1'b0;
            rst_pulse = 1'b1;
         end
         req_valid = ($urandom_range(0, 2) != 0);
         req_wr    = $urandom_range(0, 1) == 1;
         req_addr  = 3'($urandom_range(0, 7));
         req_wdata = 8'($urandom);
         rsp_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
